// File: rtl/gopf_pkg.sv
// Shared types and constants for the GF(2^m) exponentiation sequencer.
package gopf_pkg;

    localparam int GOPF_DAT_W = 144;
    localparam int GOPF_EXP_W = 16;

    localparam logic [GOPF_DAT_W-1:0] ONE = GOPF_DAT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLR,
        ST_START,
        ST_WAIT,
        ST_FIN
    } state_e;

    typedef enum logic {
        OP_SQR,
        OP_MUL
    } op_e;

    // Never returns less than 1 so that derived counters keep a legal width.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/gopf_msb_enc.sv
// Priority encoder: index of the highest set bit of val_i, plus an all-zero flag.
module gopf_msb_enc
    import gopf_pkg::*;
#(
    parameter int W  = GOPF_EXP_W,
    parameter int KW = clog2(W)
) (
    input  logic [W-1:0]  val_i,
    output logic [KW-1:0] k_o,
    output logic          zero_o
);

    always_comb begin
        k_o = '0;
        for (int j = 0; j < W; j++) begin
            if (val_i[j]) k_o = KW'(j);
        end
    end

    assign zero_o = ~|val_i;

endmodule

// File: rtl/gopf_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared GF(2^m) multiplier.
//   state | meaning
//   IDLE  | wait for start, latch operands
//   LOAD  | find exponent MSB, seed accumulator
//   CLR   | clear multiplier, present operands
//   START | pulse mul_start, load wait counter
//   WAIT  | count down multiplier latency, capture product
//   FIN   | publish result, pulse done
module gopf_exp_ctrl
    import gopf_pkg::*;
#(
    parameter int DAT_W   = GOPF_DAT_W,
    parameter int EXP_W   = GOPF_EXP_W,
    parameter int MUL_LAT = 144
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [DAT_W-1:0] base,
    input  logic [EXP_W-1:0] exp,
    input  logic [DAT_W-1:0] mod,
    output logic             busy,
    output logic             done,
    output logic [DAT_W-1:0] result,
    output logic             mul_rst_b,
    output logic             mul_start,
    output logic [DAT_W-1:0] mul_a,
    output logic [DAT_W-1:0] mul_b,
    output logic [DAT_W-1:0] mul_mod,
    input  logic [DAT_W-1:0] mul_out
);

    localparam int KW    = clog2(EXP_W);
    localparam int CNT_W = clog2(MUL_LAT);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [DAT_W-1:0]   base_q, base_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic [DAT_W-1:0]   mod_q, mod_d;
    logic [DAT_W-1:0]   acc_q, acc_d;
    logic [DAT_W-1:0]   result_q, result_d;
    logic [KW-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]      msb_k;
    logic               exp_zero;

    gopf_msb_enc #(.W(EXP_W), .KW(KW)) u_msb_enc (
        .val_i  (exp_q),
        .k_o    (msb_k),
        .zero_o (exp_zero)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_SQR;
            base_q   <= '0;
            exp_q    <= '0;
            mod_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            mod_q    <= mod_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        base_d   = base_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d  = base;
                    exp_d   = exp;
                    mod_d   = mod;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (exp_zero) begin
                    acc_d   = DAT_W'(ONE);
                    state_d = ST_FIN;
                end else begin
                    acc_d = base_q;
                    if (msb_k == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = msb_k - KW'(1);
                        op_d    = OP_SQR;
                        state_d = ST_CLR;
                    end
                end
            end
            ST_CLR:   state_d = ST_START;
            ST_START: begin
                cnt_d   = CNT_W'(MUL_LAT - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_d = mul_out;
                    if (op_q == OP_SQR && exp_q[idx_q]) begin
                        op_d    = OP_MUL;
                        state_d = ST_CLR;
                    end else if (idx_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        idx_d   = idx_q - KW'(1);
                        op_d    = OP_SQR;
                        state_d = ST_CLR;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // result is already valid in the FIN cycle alongside done
        if (state_d == ST_FIN) result_d = acc_d;
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mul_rst_b = 1'b1;
        mul_start = 1'b0;
        mul_b     = acc_q;
        case (state_q)
            ST_LOAD:  busy = 1'b1;
            ST_CLR: begin
                busy      = 1'b1;
                mul_rst_b = 1'b0;
            end
            ST_START: begin
                busy      = 1'b1;
                mul_start = 1'b1;
            end
            ST_WAIT:  busy = 1'b1;
            ST_FIN:   done = 1'b1;
            default:  busy = 1'b0;
        endcase
        if (op_q == OP_MUL) mul_b = base_q;
    end

    assign mul_a   = acc_q;
    assign mul_mod = mod_q;
    assign result  = result_q;

endmodule

// File: tb/tb_gopf_exp_ctrl.sv
// Bench for gopf_exp_ctrl over GF(2^8) with the AES polynomial and a 4-cycle multiplier model.
module tb_gopf_exp_ctrl;

    localparam int DW  = 8;
    localparam int EW  = 16;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] base_s = '0;
    logic [EW-1:0] exp_s = '0;
    logic [DW-1:0] mod_s = 8'h1B;
    logic [DW-1:0] mul_out = '0;
    logic          busy, done, mul_rst_b, mul_start;
    logic [DW-1:0] result, mul_a, mul_b, mul_mod;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    gopf_exp_ctrl #(.DAT_W(DW), .EXP_W(EW), .MUL_LAT(LAT)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .start     (start),
        .base      (base_s),
        .exp       (exp_s),
        .mod       (mod_s),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .mul_rst_b (mul_rst_b),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_mod   (mul_mod),
        .mul_out   (mul_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ m) : (x << 1);
        end
        return p;
    endfunction

    // Multiplicative group has order 255, so the exponent reduces mod 255.
    function automatic logic [7:0] ref_pow(input logic [7:0] b, input logic [15:0] e);
        logic [7:0] r;
        int ee;
        if (e == 0) return 8'h01;
        if (b == 0) return 8'h00;
        ee = int'(e) % 255;
        if (ee == 0) ee = 255;
        r = 8'h01;
        for (int i = 0; i < ee; i++) r = gmul(r, b, 8'h1B);
        return r;
    endfunction

    // Multiplier model: output valid in the LAT-th cycle counting the start cycle.
    logic [7:0] pend = '0, la = '0, lb = '0;
    int         cd = 0;
    bit         prev_clr = 1'b0, act = 1'b0;
    int         viol_order = 0, viol_stable = 0;
    logic [7:0] rec_a[$], rec_b[$];

    always @(posedge clk) begin
        prev_clr <= !mul_rst_b;
        if (!mul_rst_b || !busy) act <= 1'b0;
        if (!mul_rst_b) begin
            cd      <= 0;
            mul_out <= 8'($urandom);
        end else if (mul_start) begin
            if (!prev_clr) viol_order <= viol_order + 1;
            rec_a.push_back(mul_a);
            rec_b.push_back(mul_b);
            pend <= gmul(mul_a, mul_b, mul_mod);
            la   <= mul_a;
            lb   <= mul_b;
            act  <= 1'b1;
            cd   <= LAT - 2;
        end else begin
            if (act && busy && (mul_a !== la || mul_b !== lb)) viol_stable <= viol_stable + 1;
            if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) mul_out <= pend;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_done"},      32'(done), 32'd0);
        check({tag, "_result"},    32'(result), 32'd0);
        check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
        check({tag, "_mul_rst_b"}, 32'(mul_rst_b), 32'd1);
        check({tag, "_mul_a"},     32'(mul_a), 32'd0);
        check({tag, "_mul_b"},     32'(mul_b), 32'd0);
        check({tag, "_mul_mod"},   32'(mul_mod), 32'd0);
    endtask

    task automatic run_job(input logic [7:0] b, input logic [15:0] e, input bit repulse);
        int         k, nops, t0, guard, idx0, lat, mism;
        logic [7:0] acc, want;
        logic [7:0] ea[$], eb[$];
        k = 0;
        for (int i = 0; i < EW; i++) if (e[i]) k = i;
        nops = (e <= 1) ? 0 : k + $countones(e) - 1;
        acc = b;
        for (int i = k - 1; i >= 0; i--) begin
            ea.push_back(acc); eb.push_back(acc);
            acc = gmul(acc, acc, 8'h1B);
            if (e[i]) begin
                ea.push_back(acc); eb.push_back(b);
                acc = gmul(acc, b, 8'h1B);
            end
        end
        want = ref_pow(b, e);
        idx0 = rec_a.size();

        @(negedge clk);
        base_s = b; exp_s = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        base_s = 8'($urandom);
        exp_s  = 16'($urandom);
        check("busy_cycle1", 32'(busy), 32'd1);
        guard = 0;
        while (done !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (repulse && guard == 10) begin
                start = 1'b1; base_s = 8'h02; exp_s = 16'd2;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        lat = cyc - t0 + 1;
        check("done_seen",    32'(done), 32'd1);
        check("latency",      32'(lat), 32'(2 + nops * (LAT + 2)));
        check("result",       32'(result), 32'(want));
        check("busy_at_done", 32'(busy), 32'd0);
        check("n_mul_ops",    32'(rec_a.size() - idx0), 32'(nops));
        mism = 0;
        for (int j = 0; j < ea.size(); j++) begin
            if (idx0 + j >= rec_a.size()) mism++;
            else if (rec_a[idx0 + j] !== ea[j] || rec_b[idx0 + j] !== eb[j]) mism++;
        end
        check("operand_seq",      32'(mism), 32'd0);
        check("clr_before_start", 32'(viol_order), 32'd0);
        check("operand_stable",   32'(viol_stable), 32'd0);
        check("mul_mod_fwd",      32'(mul_mod), 32'h1B);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_hold",    32'(result), 32'(want));
    endtask

    initial begin
        int  guard;
        bit  seen, got_done;
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_b = 1'b1;

        run_job(8'h53, 16'd0, 1'b0);
        check("exp0_value", 32'(result), 32'h01);
        run_job(8'h53, 16'd1, 1'b0);
        check("exp1_value", 32'(result), 32'h53);
        run_job(8'h02, 16'd8, 1'b0);
        check("x8_value", 32'(result), 32'h1B);
        run_job(8'h53, 16'd254, 1'b1);
        check("inverse_value", 32'(result), 32'hCA);

        repeat (8) run_job(8'($urandom), 16'($urandom_range(0, 300)), 1'b0);
        run_job(8'($urandom_range(1, 255)), 16'hFFFF, 1'b0);

        // Abort a job with reset while it is waiting on the multiplier.
        @(negedge clk);
        base_s = 8'h53; exp_s = 16'd254; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 50) begin
            @(negedge clk);
            guard++;
            if (mul_start === 1'b1) seen = 1'b1;
        end
        check("abort_reached_mul", 32'(seen), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_b = 1'b1;
        got_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) got_done = 1'b1;
        end
        check("abort_no_done", 32'(got_done), 32'd0);
        run_job(8'h02, 16'd2, 1'b0);
        check("post_abort_value", 32'(result), 32'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
